// File: rtl/btn_pkg.sv
// Shared constants, event type and width helper for the push-button conditioner.
package btn_pkg;

    localparam int unsigned BTN_N_DEFAULT = 7;
    localparam logic [BTN_N_DEFAULT-1:0] ULX3S_BTN_ACTIVE_LOW = 7'b0000001;

    typedef enum logic [1:0] {
        EV_NONE    = 2'd0,
        EV_PRESS   = 2'd1,
        EV_RELEASE = 2'd2
    } btn_event_e;

    // Bits needed to hold 0..value-1, never less than one.
    function automatic int unsigned clog2_min1(input int unsigned value);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(value)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/btn_debounce_if.sv
// Button bundle: normalised raw input plus debounced level and event pulses.
interface btn_debounce_if #(
    parameter int unsigned W = 1
);
    logic [W-1:0] raw;
    logic [W-1:0] level;
    logic [W-1:0] press;
    logic [W-1:0] rel;

    modport master (output raw, input level, input press, input rel);
    modport slave  (input raw, output level, output press, output rel);
endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF sync, stability counter, press/release pulses.
// Auto-repeat on held buttons is built only when BTN_REPEAT_EN is defined.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_DELAY    = 12500000,
    parameter int unsigned REPEAT_PERIOD   = 2500000
) (
    input  logic           i_clk,
    input  logic           i_reset,
    btn_debounce_if.slave  bif
);

    localparam int unsigned CNT_W = clog2_min1(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("btn_debounce_ch: DEBOUNCE_CYCLES must be at least 2");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("btn_debounce_ch: REPEAT_DELAY and REPEAT_PERIOD must be non-zero");
    end

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_press;
    logic             r_release;
    logic [CNT_W-1:0] r_cnt;
    btn_event_e       w_event;
    logic             w_rep_fire;

    always_comb begin
        w_event = EV_NONE;
        if ((r_sync2 != r_stable) && (r_cnt == CNT_LAST)) begin
            w_event = r_sync2 ? EV_PRESS : EV_RELEASE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_stable  <= 1'b0;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1 <= bif.raw[0];
            r_sync2 <= r_sync1;
            // Any sample matching the accepted level restarts the count.
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (w_event != EV_NONE) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_press   <= (w_event == EV_PRESS) | w_rep_fire;
            r_release <= (w_event == EV_RELEASE);
        end
    end

`ifdef BTN_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned REP_W   = clog2_min1(REP_MAX + 1);

    logic [REP_W-1:0] r_rcnt;
    logic             r_rphase;
    logic [REP_W-1:0] w_rep_last;

    // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD; a release edge wins.
    always_comb begin
        w_rep_last = r_rphase ? REP_W'(REPEAT_PERIOD - 1) : REP_W'(REPEAT_DELAY - 1);
        w_rep_fire = r_stable && (w_event == EV_NONE) && (r_rcnt == w_rep_last);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || !r_stable || (w_event != EV_NONE)) begin
            r_rcnt   <= '0;
            r_rphase <= 1'b0;
        end else if (w_rep_fire) begin
            r_rcnt   <= '0;
            r_rphase <= 1'b1;
        end else begin
            r_rcnt <= r_rcnt + REP_W'(1);
        end
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    assign bif.level = r_stable;
    assign bif.press = r_press;
    assign bif.rel   = r_release;

endmodule

// File: rtl/btn_debounce.sv
// ULX3S push-button conditioner: polarity normalisation and per-channel debounce.
// Optional auto-repeat of o_press is enabled by defining BTN_REPEAT_EN.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned        N_BTN           = BTN_N_DEFAULT,
    parameter logic [N_BTN-1:0]   ACTIVE_LOW_MASK = N_BTN'(ULX3S_BTN_ACTIVE_LOW),
    parameter int unsigned        DEBOUNCE_CYCLES = 250000,
    parameter int unsigned        REPEAT_DELAY    = 12500000,
    parameter int unsigned        REPEAT_PERIOD   = 2500000
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] o_level,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release
);

    logic [N_BTN-1:0] w_norm;

    assign w_norm = btn ^ ACTIVE_LOW_MASK;

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_debounce_if #(.W(1)) u_if ();

        assign u_if.raw = w_norm[g];

        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .i_clk  (i_clk),
            .i_reset(i_reset),
            .bif    (u_if)
        );

        assign o_level[g]   = u_if.level[0];
        assign o_press[g]   = u_if.press[0];
        assign o_release[g] = u_if.rel[0];
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed scenarios plus random bouncing against a window model.
module tb_btn_debounce;

    localparam int unsigned N  = 7;
    localparam int unsigned D  = 8;
    localparam int unsigned RD = 20;
    localparam int unsigned RP = 5;
    localparam logic [N-1:0] MASK = 7'b0000001;
    localparam logic [N-1:0] IDLE = 7'b0000001;
`ifdef BTN_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic clk;
    logic i_reset;
    int   n_checks;
    int   n_errors;

    btn_debounce_if #(.W(N)) bus ();

    btn_debounce #(
        .N_BTN          (N),
        .ACTIVE_LOW_MASK(MASK),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .i_clk    (clk),
        .i_reset  (i_reset),
        .btn      (bus.raw),
        .o_level  (bus.level),
        .o_press  (bus.press),
        .o_release(bus.rel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a level is accepted once the D pin samples taken two or more
    // edges ago all disagree with it; repeats fall at fixed offsets from the press.
    logic [N-1:0] m_level, m_press, m_rel, m_nrm;
    logic [D:0]   m_hist [N];
    int unsigned  m_cyc;
    int unsigned  m_pcyc [N];
    logic         m_acc;
    int unsigned  m_age;

    initial begin
        m_level = '0; m_press = '0; m_rel = '0; m_cyc = 0;
        for (int c = 0; c < N; c++) begin
            m_hist[c] = '0;
            m_pcyc[c] = 0;
        end
        forever begin
            @(posedge clk);
            m_nrm = bus.raw ^ MASK;
            m_cyc = m_cyc + 1;
            if (i_reset) begin
                m_level = '0; m_press = '0; m_rel = '0;
                for (int c = 0; c < N; c++) m_hist[c] = '0;
            end else begin
                for (int c = 0; c < N; c++) begin
                    m_acc = (m_hist[c][D:1] == {D{~m_level[c]}});
                    m_press[c] = 1'b0;
                    m_rel[c]   = 1'b0;
                    if (m_acc) begin
                        if (!m_level[c]) begin
                            m_press[c] = 1'b1;
                            m_pcyc[c]  = m_cyc;
                        end else begin
                            m_rel[c] = 1'b1;
                        end
                        m_level[c] = ~m_level[c];
                    end else if (REP && m_level[c]) begin
                        m_age = m_cyc - m_pcyc[c];
                        if (m_age >= RD && ((m_age - RD) % RP) == 0) m_press[c] = 1'b1;
                    end
                    m_hist[c] = {m_hist[c][D-1:0], m_nrm[c]};
                end
            end
        end
    end

    task automatic test_reset;
        for (int j = 0; j < 23; j++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({bus.level, bus.press, bus.rel} !== 21'd0) begin
                n_errors++;
                $display("FAIL reset_quiet j=%0d: lvl=%b prs=%b rel=%b, required all 0", j, bus.level, bus.press, bus.rel);
            end
            if (j == 2) i_reset = 1'b0;
        end
    endtask

    task automatic test_single_press;
        for (int j = 0; j < 60; j++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({bus.level, bus.press, bus.rel} !== {m_level, m_press, m_rel}) begin
                n_errors++;
                $display("FAIL single_model j=%0d: got %b/%b/%b required %b/%b/%b", j, bus.level, bus.press, bus.rel, m_level, m_press, m_rel);
            end
            if (j == 19 || j == 20) begin
                n_checks++;
                if (bus.level !== 7'b0001000 || bus.press !== ((j == 19) ? 7'b0001000 : 7'b0)) begin
                    n_errors++;
                    $display("FAIL single_press j=%0d: lvl=%b prs=%b", j, bus.level, bus.press);
                end
            end
            if (j == 49) begin
                n_checks++;
                if (bus.rel !== 7'b0001000 || bus.level !== 7'b0) begin
                    n_errors++;
                    $display("FAIL single_release: rel=%b lvl=%b required 0001000/0000000", bus.rel, bus.level);
                end
            end
            if (j == 9)  bus.raw[3] = 1'b1;
            if (j == 39) bus.raw[3] = 1'b0;
        end
    endtask

    task automatic test_bounce;
        for (int j = 0; j < 70; j++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({bus.level, bus.press, bus.rel} !== {m_level, m_press, m_rel}) begin
                n_errors++;
                $display("FAIL bounce_model j=%0d: got %b/%b/%b required %b/%b/%b", j, bus.level, bus.press, bus.rel, m_level, m_press, m_rel);
            end
            if (j < 28) begin
                n_checks++;
                if (bus.press[2] !== (j == 27) || bus.level[2] !== (j >= 27)) begin
                    n_errors++;
                    $display("FAIL bounce_glitch j=%0d: prs2=%b lvl2=%b required %b/%b", j, bus.press[2], bus.level[2], (j == 27), (j >= 27));
                end
            end
            if (j == 9)  bus.raw[2] = 1'b1;
            if (j == 16) bus.raw[2] = 1'b0;
            if (j == 17) bus.raw[2] = 1'b1;
            if (j == 44) bus.raw[2] = 1'b0;
        end
    endtask

    task automatic test_active_low;
        for (int j = 0; j < 50; j++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({bus.level, bus.press, bus.rel} !== {m_level, m_press, m_rel}) begin
                n_errors++;
                $display("FAIL actlow_model j=%0d: got %b/%b/%b required %b/%b/%b", j, bus.level, bus.press, bus.rel, m_level, m_press, m_rel);
            end
            if (j == 19 || j == 39) begin
                n_checks++;
                if (bus.press !== ((j == 19) ? 7'b0000001 : 7'b0) || bus.rel !== ((j == 39) ? 7'b0000001 : 7'b0)) begin
                    n_errors++;
                    $display("FAIL actlow_pulse j=%0d: prs=%b rel=%b", j, bus.press, bus.rel);
                end
            end
            if (j == 9)  bus.raw[0] = 1'b0;
            if (j == 29) bus.raw[0] = 1'b1;
        end
    endtask

    task automatic test_simul_reset;
        for (int j = 0; j < 65; j++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({bus.level, bus.press, bus.rel} !== {m_level, m_press, m_rel}) begin
                n_errors++;
                $display("FAIL simul_model j=%0d: got %b/%b/%b required %b/%b/%b", j, bus.level, bus.press, bus.rel, m_level, m_press, m_rel);
            end
            if (j == 19 || j == 36) begin
                n_checks++;
                if (bus.press !== 7'b0100010 || bus.level !== 7'b0100010) begin
                    n_errors++;
                    $display("FAIL simul_press j=%0d: prs=%b lvl=%b required 0100010", j, bus.press, bus.level);
                end
            end
            if (j == 25 || j == 26) begin
                n_checks++;
                if ({bus.level, bus.press, bus.rel} !== 21'd0) begin
                    n_errors++;
                    $display("FAIL simul_reset j=%0d: lvl=%b prs=%b rel=%b required 0", j, bus.level, bus.press, bus.rel);
                end
            end
            if (j == 9)  begin bus.raw[1] = 1'b1; bus.raw[5] = 1'b1; end
            if (j == 24) i_reset = 1'b1;
            if (j == 26) i_reset = 1'b0;
            if (j == 44) begin bus.raw[1] = 1'b0; bus.raw[5] = 1'b0; end
        end
    endtask

    task automatic test_repeat;
        int presses;
        presses = 0;
        for (int j = 0; j < 80; j++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({bus.level, bus.press, bus.rel} !== {m_level, m_press, m_rel}) begin
                n_errors++;
                $display("FAIL repeat_model j=%0d: got %b/%b/%b required %b/%b/%b", j, bus.level, bus.press, bus.rel, m_level, m_press, m_rel);
            end
            if (bus.press[4] === 1'b1) presses++;
            if (j == 39) begin
                n_checks++;
                if (bus.press[4] !== REP) begin
                    n_errors++;
                    $display("FAIL repeat_first: prs4=%b required %b", bus.press[4], REP);
                end
            end
            if (j == 69) begin
                n_checks++;
                if (bus.rel[4] !== 1'b1 || bus.press[4] !== 1'b0) begin
                    n_errors++;
                    $display("FAIL repeat_release: rel4=%b prs4=%b required 1/0", bus.rel[4], bus.press[4]);
                end
            end
            if (j == 9)  bus.raw[4] = 1'b1;
            if (j == 59) bus.raw[4] = 1'b0;
        end
        n_checks++;
        if (presses != (REP ? 7 : 1)) begin
            n_errors++;
            $display("FAIL repeat_count: got %0d presses required %0d", presses, (REP ? 7 : 1));
        end
    endtask

    task automatic test_random;
        int hold [N];
        for (int c = 0; c < N; c++) hold[c] = 0;
        for (int j = 0; j < 3040; j++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({bus.level, bus.press, bus.rel} !== {m_level, m_press, m_rel}) begin
                n_errors++;
                $display("FAIL random_model j=%0d: got %b/%b/%b required %b/%b/%b", j, bus.level, bus.press, bus.rel, m_level, m_press, m_rel);
            end
            n_checks++;
            if ((bus.press & bus.rel) !== 7'b0) begin
                n_errors++;
                $display("FAIL random_exclusive j=%0d: prs=%b rel=%b", j, bus.press, bus.rel);
            end
            if (j < 3000) begin
                for (int c = 0; c < N; c++) begin
                    if (hold[c] == 0) begin
                        bus.raw[c] = 1'($urandom_range(0, 1));
                        hold[c] = int'($urandom_range(1, 24));
                    end else begin
                        hold[c] = hold[c] - 1;
                    end
                end
                i_reset = ($urandom_range(0, 399) == 0);
            end else begin
                bus.raw = IDLE;
                i_reset = 1'b0;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        i_reset  = 1'b1;
        bus.raw  = IDLE;
        test_reset();
        test_single_press();
        test_bounce();
        test_active_low();
        test_simul_reset();
        test_repeat();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
